prog_counter8_ctrl: RTL

- Command-driven initiator for the 8-bit programmable counter; produces its EN/LOAD/UP/OE controls and parallel-load value, and reads back its count bus and status pins.
- Accepts LOAD / STEP_UP / STEP_DOWN / READ commands over a valid/ready interface.
- Keeps a shadow model of the expected count, checks readback and load/wrap status against it, and returns one response per command.
- Used as an on-chip self-test and sequencing front end for the counter.

---
 rtl/prog_counter8_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/prog_counter8_ctrl.sv
// Command-driven sequencer and checker for the 8-bit programmable counter.
// Latency: LOAD 3 cycles, STEP N+2 cycles, READ SETTLE+1 cycles, each plus the response handshake.
// Backpressure: one command in flight; cmd_ready only in IDLE; the response is held until rsp_ready.
module prog_counter8_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       ctr_en,
  output logic       ctr_load,
  output logic       ctr_up,
  output logic       ctr_oe,
  output logic [7:0] ctr_pval,
  input  logic [7:0] ctr_cnt,
  input  logic [7:0] ctr_status,
  output logic [7:0] wrap_total
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_CHK,
    ST_STEP,
    ST_STEP_TAIL,
    ST_READ_WAIT,
    ST_RESP
  } state_t;

  state_t     state;
  logic [1:0] op_q;
  logic [4:0] arg_lo;       // only the low bits are needed after acceptance (status readback check)
  logic [7:0] model;        // shadow of the count the counter should hold
  logic [8:0] steps_left;   // 9 bits so an argument of 0 can mean 256 steps
  logic [3:0] settle_left;
  logic [8:0] wrap_exp;     // wraps predicted from the model for this command
  logic [8:0] wrap_obs;     // wrap pulses seen on the status pins for this command

  // Carry/borrow is not checked; the wrap pulse already covers the boundary crossing.
  logic status_unused;
  assign status_unused = ctr_status[6];

  // Count wrap pulses including the current cycle's pulse, for the final comparison in STEP_TAIL.
  logic [8:0] wrap_obs_final;
  assign wrap_obs_final = wrap_obs + {8'd0, ctr_status[7]};

  // Command FSM: sequences the counter pins, updates the shadow model and builds the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_err     <= 1'b0;
      ctr_en      <= 1'b0;
      ctr_load    <= 1'b0;
      ctr_up      <= 1'b0;
      ctr_oe      <= 1'b0;
      ctr_pval    <= 8'h00;
      wrap_total  <= 8'h00;
      op_q        <= OP_LOAD;
      arg_lo      <= 5'd0;
      model       <= 8'h00;
      steps_left  <= 9'd0;
      settle_left <= 4'd0;
      wrap_exp    <= 9'd0;
      wrap_obs    <= 9'd0;
    end else begin
      // Wrap pulses lag the enabled edges by one cycle, so the window is all STEP cycles plus STEP_TAIL.
      if ((state == ST_STEP || state == ST_STEP_TAIL) && ctr_status[7]) begin
        wrap_obs <= wrap_obs + 9'd1;
        if (wrap_total != 8'hFF) wrap_total <= wrap_total + 8'h01;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            arg_lo    <= cmd_arg[4:0];
            rsp_err   <= 1'b0;
            wrap_exp  <= 9'd0;
            wrap_obs  <= 9'd0;
            case (cmd_op)
              OP_LOAD: begin
                ctr_load <= 1'b1;
                ctr_pval <= cmd_arg;
                model    <= cmd_arg;
                state    <= ST_LOAD;
              end
              OP_UP, OP_DOWN: begin
                ctr_en     <= 1'b1;
                ctr_up     <= (cmd_op == OP_UP);
                steps_left <= (cmd_arg == 8'h00) ? 9'd256 : {1'b0, cmd_arg};
                state      <= ST_STEP;
              end
              default: begin
                ctr_oe      <= 1'b1;
                settle_left <= 4'(SETTLE);
                state       <= ST_READ_WAIT;
              end
            endcase
          end
        end

        ST_LOAD: begin
          ctr_load <= 1'b0;
          state    <= ST_LOAD_CHK;
        end

        ST_LOAD_CHK: begin
          rsp_err   <= !ctr_status[5] || (ctr_status[4:0] != arg_lo);
          rsp_data  <= model;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_STEP: begin
          if (op_q == OP_UP) begin
            if (model == 8'hFF) wrap_exp <= wrap_exp + 9'd1;
            model <= model + 8'h01;
          end else begin
            if (model == 8'h00) wrap_exp <= wrap_exp + 9'd1;
            model <= model - 8'h01;
          end
          if (steps_left == 9'd1) begin
            ctr_en <= 1'b0;
            ctr_up <= 1'b0;
            state  <= ST_STEP_TAIL;
          end else begin
            steps_left <= steps_left - 9'd1;
          end
        end

        ST_STEP_TAIL: begin
          rsp_err   <= (wrap_obs_final != wrap_exp);
          rsp_data  <= model;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_READ_WAIT: begin
          if (settle_left <= 4'd1) begin
            ctr_oe    <= 1'b0;
            rsp_data  <= ctr_cnt;
            rsp_err   <= (ctr_cnt != model);
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            settle_left <= settle_left - 4'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
